reg_bank_arbiter: RTL

- Shares the single write port of a small bank of 4-bit registers among NREQ requesters, using round-robin arbitration and a req/ack handshake.
- Sequences each write as IDLE -> WRITE -> ACK, so every transaction takes exactly 3 cycles.
- Provides one combinational read port.
- Sits between lab-level control logic (switch/button requesters) and the register storage.

---
 rtl/reg_bank_pkg.sv | 21 ++
 rtl/reg_bank_arbiter_rr_pick.sv | 32 +++
 rtl/reg_bank_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the arbitrated register bank: FSM state encoding and
// default geometry (requesters, data width, bank depth, address width).
package reg_bank_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   localparam int NREQ_DEF = 4;
   localparam int DW_DEF   = 4;
   localparam int NREG_DEF = 4;
   localparam int AW_DEF   = 2;

   // Index width for requester pointers; never below 1 bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping modulo NREQ.
// Pure logic, no state; valid is low when no request is pending.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic            valid,
   output logic [PW-1:0]   idx
);

   int w_j;

   // Scan from farthest to nearest so the closest hit to ptr is written last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      w_j   = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_j = int'(ptr) + k;
         if (w_j >= NREQ) begin
            w_j = w_j - NREQ;
         end
         if (req[w_j]) begin
            valid = 1'b1;
            idx   = PW'(w_j);
         end
      end
   end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin arbitrated single write port onto a small register bank, IDLE->WRITE->ACK per write.
// Optional macro RD_BYPASS_EN forwards the staged write data to the read port during WRITE.
module reg_bank_arbiter
   import reg_bank_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DW   = DW_DEF,
   parameter int NREG = NREG_DEF,
   parameter int AW   = AW_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*AW-1:0] wr_addr,
   input  logic [NREQ*DW-1:0] wr_data,
   output logic [NREQ-1:0]   ack,
   output logic              busy,
   input  logic [AW-1:0]     rd_addr,
   output logic [DW-1:0]     rd_data
);

   localparam int PW = idx_width(NREQ);

   state_t          r_state;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   r_gnt_idx;
   logic [AW-1:0]   r_stg_addr;
   logic [DW-1:0]   r_stg_data;
   logic [NREQ-1:0] r_ack;
   logic [DW-1:0]   r_bank [NREG];

   logic            w_pick_vld;
   logic [PW-1:0]   w_pick_idx;
   logic [DW-1:0]   w_rd_data;

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .req   (req),
      .ptr   (r_ptr),
      .valid (w_pick_vld),
      .idx   (w_pick_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_gnt_idx  <= '0;
         r_stg_addr <= '0;
         r_stg_data <= '0;
         r_ack      <= '0;
         for (int i = 0; i < NREG; i++) begin
            r_bank[i] <= '0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ack <= '0;
               if (w_pick_vld) begin
                  r_gnt_idx  <= w_pick_idx;
                  r_stg_addr <= wr_addr[w_pick_idx*AW +: AW];
                  r_stg_data <= wr_data[w_pick_idx*DW +: DW];
                  r_state    <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               r_bank[r_stg_addr] <= r_stg_data;
               r_ack              <= '0;
               r_ack[r_gnt_idx]   <= 1'b1;
               r_state            <= ST_ACK;
            end
            ST_ACK: begin
               r_ack   <= '0;
               r_ptr   <= (r_gnt_idx == PW'(NREQ - 1)) ? '0 : r_gnt_idx + 1'b1;
               r_state <= ST_IDLE;
            end
            default: begin
               r_ack   <= '0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign ack  = r_ack;
   assign busy = (r_state != ST_IDLE);

   always_comb begin
      w_rd_data = r_bank[rd_addr];
`ifdef RD_BYPASS_EN
      if ((r_state == ST_WRITE) && (rd_addr == r_stg_addr)) begin
         w_rd_data = r_stg_data;
      end
`else
`endif
   end

   assign rd_data = w_rd_data;

endmodule
